alu_seq_top: RTL and testbench

- Parametrised successor to the Stage-3 ALU.
- Keeps the X/Y source muxes and the single-cycle arith/logic/shift/SLT path, now at WIDTH bits.
- Adds an iterative multiply/divide engine behind a valid/ready handshake.
- All results leave through a registered Z port with a valid strobe, so the pipeline can stall on multi-cycle ops.

---
 rtl/alu_seq_top.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_seq_top.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - WIDTH-bit ALU with iterative MUL/DIV and registered Z port; `ALU_SIGNED_MD_EN enables signed MUL/DIV
module alu_seq_top #(
    parameter int WIDTH     = 32,
    parameter int PC_INC    = 4,
    parameter int OFS_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             flush,
    input  logic [1:0]       alusrcx,
    input  logic [1:0]       alusrcy,
    input  logic [2:0]       fntype,
    input  logic             addsub,
    input  logic [1:0]       logicfn,
    input  logic             md_signed,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic [WIDTH-1:0] imm_in,
    output logic [WIDTH-1:0] z_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             z_valid,
    output logic             alu_zero,
    output logic             ovfl,
    output logic             div0
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] FN_ARITH = 3'd0;
    localparam logic [2:0] FN_LOGIC = 3'd1;
    localparam logic [2:0] FN_SHIFT = 3'd2;
    localparam logic [2:0] FN_SLT   = 3'd3;
    localparam logic [2:0] FN_MUL   = 3'd4;
    localparam logic [2:0] FN_DIV   = 3'd5;

    logic [2:0]       state;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             md_div;
    logic             md_sgn;
    logic             neg_q;
    logic             neg_r;

    logic             sgn_req;
`ifdef ALU_SIGNED_MD_EN
    assign sgn_req = md_signed;
`else
    logic md_signed_unused;
    assign md_signed_unused = md_signed;
    assign sgn_req = 1'b0;
`endif

    assign op_ready = (state == ST_IDLE);

    logic [WIDTH-1:0]   src_x, src_y, y_eff, arith_res, logic_res, shift_res, sc_res;
    logic [2*WIDTH-1:0] ror_wide;
    logic [SW-1:0]      shamt;
    logic               do_sub, sc_ovfl, is_arith;

    always_comb begin
        case (alusrcx)
            2'b00:   src_x = pc_in;
            2'b01:   src_x = x_in;
            2'b10:   src_x = z_in;
            default: src_x = '0;
        endcase
        case (alusrcy)
            2'b00:   src_y = WIDTH'(PC_INC);
            2'b01:   src_y = y_in;
            2'b10:   src_y = imm_in;
            default: src_y = imm_in << OFS_SHIFT;
        endcase
    end

    // Reserved codes fall into the add path, so only 000 honours addsub.
    always_comb begin
        is_arith  = (fntype != FN_LOGIC) && (fntype != FN_SHIFT) && (fntype != FN_SLT);
        do_sub    = (fntype == FN_SLT) || ((fntype == FN_ARITH) && addsub);
        y_eff     = do_sub ? ~src_y : src_y;
        arith_res = src_x + y_eff + WIDTH'(do_sub);
        sc_ovfl   = is_arith && (src_x[WIDTH-1] == y_eff[WIDTH-1])
                    && (arith_res[WIDTH-1] != src_x[WIDTH-1]);
        case (logicfn)
            2'b00:   logic_res = src_x & src_y;
            2'b01:   logic_res = src_x | src_y;
            2'b10:   logic_res = src_x ^ src_y;
            default: logic_res = ~(src_x | src_y);
        endcase
        shamt    = src_y[SW-1:0];
        ror_wide = {src_x, src_x} >> shamt;
        case (logicfn)
            2'b00:   shift_res = ror_wide[WIDTH-1:0];
            2'b01:   shift_res = src_x >> shamt;
            2'b10:   shift_res = src_x << shamt;
            default: shift_res = $signed(src_x) >>> shamt;
        endcase
        case (fntype)
            FN_LOGIC: sc_res = logic_res;
            FN_SHIFT: sc_res = shift_res;
            FN_SLT:   sc_res = {{(WIDTH-1){1'b0}}, arith_res[WIDTH-1]};
            default:  sc_res = arith_res;
        endcase
    end

    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;

    always_comb begin
        x_neg = sgn_req && src_x[WIDTH-1];
        y_neg = sgn_req && src_y[WIDTH-1];
        x_mag = x_neg ? -src_x : src_x;
        y_mag = y_neg ? -src_y : src_y;
    end

    // One shift-add or restoring-divide step; DIV keeps the partial remainder in acc_hi.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift - {1'b0, opb};
        if (state == ST_DIV) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               fix_ovfl;

    always_comb begin
        prod_neg = -{acc_hi, acc_lo};
        if (md_div) begin
            fix_lo = neg_q ? -acc_lo : acc_lo;
            fix_hi = neg_r ? -acc_hi : acc_hi;
        end else begin
            {fix_hi, fix_lo} = neg_q ? prod_neg : {acc_hi, acc_lo};
        end
        // A positive quotient of magnitude 2^(WIDTH-1) only arises from most-negative / -1.
        fix_ovfl = md_div && !neg_q && acc_lo[WIDTH-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            md_div   <= 1'b0;
            md_sgn   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            z_out    <= '0;
            hi_out   <= '0;
            z_valid  <= 1'b0;
            alu_zero <= 1'b0;
            ovfl     <= 1'b0;
            div0     <= 1'b0;
        end else begin
            z_valid <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (op_valid) begin
                            if (fntype == FN_MUL || fntype == FN_DIV) begin
                                md_div <= (fntype == FN_DIV);
                                md_sgn <= sgn_req;
                                neg_q  <= x_neg ^ y_neg;
                                neg_r  <= x_neg;
                                opb    <= y_mag;
                                acc_hi <= '0;
                                acc_lo <= x_mag;
                                cnt    <= '0;
                                state  <= (fntype == FN_DIV) ? ST_DIV : ST_MUL;
                            end else begin
                                z_out    <= sc_res;
                                hi_out   <= '0;
                                alu_zero <= (sc_res == '0);
                                ovfl     <= sc_ovfl;
                                div0     <= 1'b0;
                                z_valid  <= 1'b1;
                            end
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        if (state == ST_DIV && opb == '0) begin
                            z_out    <= '1;
                            hi_out   <= neg_r ? -acc_lo : acc_lo;
                            alu_zero <= 1'b0;
                            ovfl     <= 1'b0;
                            div0     <= 1'b1;
                            z_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            acc_hi <= step_hi;
                            acc_lo <= step_lo;
                            cnt    <= cnt + 1'b1;
                            if (cnt == '1) begin
                                if (md_sgn) begin
                                    state <= ST_FIX;
                                end else begin
                                    z_out    <= step_lo;
                                    hi_out   <= step_hi;
                                    alu_zero <= (step_lo == '0);
                                    ovfl     <= 1'b0;
                                    div0     <= 1'b0;
                                    z_valid  <= 1'b1;
                                    state    <= ST_DONE;
                                end
                            end
                        end
                    end
                    ST_FIX: begin
                        z_out    <= fix_lo;
                        hi_out   <= fix_hi;
                        alu_zero <= (fix_lo == '0);
                        ovfl     <= fix_ovfl;
                        div0     <= 1'b0;
                        z_valid  <= 1'b1;
                        state    <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - scoreboard bench for alu_seq_top (default build, unsigned MUL/DIV)
module tb_alu_seq_top;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0, flush = 1'b0, addsub = 1'b0, md_signed = 1'b0;
    logic        op_ready, z_valid, alu_zero, ovfl, div0;
    logic [1:0]  alusrcx = 2'b00, alusrcy = 2'b00, logicfn = 2'b00;
    logic [2:0]  fntype = 3'b000;
    logic [31:0] pc_in = 32'h100, x_in = '0, y_in = '0, z_in = 32'h55, imm_in = '0;
    logic [31:0] z_out, hi_out;

    always #5 clk = ~clk;

    alu_seq_top dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .flush(flush),
        .alusrcx(alusrcx), .alusrcy(alusrcy), .fntype(fntype), .addsub(addsub),
        .logicfn(logicfn), .md_signed(md_signed), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
        .z_in(z_in), .imm_in(imm_in), .z_out(z_out), .hi_out(hi_out), .z_valid(z_valid),
        .alu_zero(alu_zero), .ovfl(ovfl), .div0(div0)
    );

    typedef struct {
        int          id;
        logic [31:0] z;
        logic [31:0] hi;
        logic        ov;
        logic        d0;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int id, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL step %0d %s: observed %h expected %h", id, what, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (z_valid) begin
            if (sb.size() == 0) begin
                check(-1, "unexpected z_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.id, "z_out", z_out, mon_e.z);
                check(mon_e.id, "hi_out", hi_out, mon_e.hi);
                check(mon_e.id, "alu_zero", alu_zero, (mon_e.z == 32'd0));
                check(mon_e.id, "ovfl", ovfl, mon_e.ov);
                check(mon_e.id, "div0", div0, mon_e.d0);
                check(mon_e.id, "latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input int id, input logic [2:0] fn, input logic [1:0] sx, input logic [1:0] sy,
                         input logic sub, input logic [1:0] lf, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ez, input logic [31:0] eh, input logic eov, input logic ed0,
                         input int lat, input bit push);
        exp_t e;
        fntype = fn; alusrcx = sx; alusrcy = sy; addsub = sub; logicfn = lf;
        x_in = x; y_in = y; imm_in = y;
        op_valid = 1'b1;
        if (push) begin
            e.id = id; e.z = ez; e.hi = eh; e.ov = eov; e.d0 = ed0; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_ready(input int id, output int lowcnt);
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (op_ready) break;
            lowcnt++;
        end
        check(id, "op_ready returns", op_ready, 1'b1);
    endtask

    int          low;
    logic [31:0] ra, rb;
    logic [63:0] prod;

    initial begin
        repeat (2) @(negedge clk);
        check(0, "reset z_out", z_out, 0);
        check(0, "reset hi_out", hi_out, 0);
        check(0, "reset z_valid", z_valid, 0);
        check(0, "reset alu_zero", alu_zero, 0);
        check(0, "reset ovfl", ovfl, 0);
        check(0, "reset div0", div0, 0);
        check(0, "reset op_ready", op_ready, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops, one result per cycle
        issue(1, 3'b000, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h104, 0, 0, 0, 1, 1);
        issue(2, 3'b000, 2'b01, 2'b01, 1'b1, 2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 0, 1, 0, 1, 1);
        issue(3, 3'b011, 2'b01, 2'b01, 1'b0, 2'b00, 32'd5, 32'd7, 32'd1, 0, 0, 0, 1, 1);
        issue(4, 3'b011, 2'b01, 2'b01, 1'b0, 2'b00, 32'h80000000, 32'd1, 32'd0, 0, 0, 0, 1, 1);
        issue(5, 3'b010, 2'b01, 2'b10, 1'b0, 2'b11, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0, 1, 1);
        issue(6, 3'b010, 2'b01, 2'b01, 1'b0, 2'b00, 32'h1, 32'd1, 32'h80000000, 0, 0, 0, 1, 1);
        issue(7, 3'b010, 2'b01, 2'b01, 1'b0, 2'b00, 32'h1, 32'd33, 32'h80000000, 0, 0, 0, 1, 1);
        issue(8, 3'b010, 2'b01, 2'b01, 1'b0, 2'b10, 32'h1, 32'd31, 32'h80000000, 0, 0, 0, 1, 1);
        issue(9, 3'b010, 2'b01, 2'b01, 1'b0, 2'b01, 32'h80000000, 32'd31, 32'h1, 0, 0, 0, 1, 1);
        issue(10, 3'b001, 2'b01, 2'b01, 1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1, 1);
        issue(11, 3'b001, 2'b01, 2'b01, 1'b0, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1, 1);
        issue(12, 3'b001, 2'b01, 2'b01, 1'b0, 2'b10, 32'h1234, 32'h1234, 32'h0, 0, 0, 0, 1, 1);
        issue(13, 3'b001, 2'b11, 2'b01, 1'b0, 2'b11, 32'h1234, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1, 1);
        issue(14, 3'b000, 2'b10, 2'b01, 1'b0, 2'b00, 32'h0, 32'h10, 32'h65, 0, 0, 0, 1, 1);
        issue(15, 3'b000, 2'b01, 2'b11, 1'b0, 2'b00, 32'd3, 32'd5, 32'd23, 0, 0, 0, 1, 1);
        issue(16, 3'b111, 2'b01, 2'b01, 1'b1, 2'b00, 32'd10, 32'd3, 32'd13, 0, 0, 0, 1, 1);
        issue(17, 3'b000, 2'b01, 2'b01, 1'b0, 2'b00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0, 1, 1);
        repeat (2) @(negedge clk);

        // Multi-cycle MUL/DIV with op_ready held low
        issue(18, 3'b100, 2'b01, 2'b01, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 0, 33, 1);
        wait_ready(18, low);
        check(18, "mul op_ready low cycles", low, 33);
        issue(19, 3'b101, 2'b01, 2'b01, 1'b0, 2'b00, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33, 1);
        wait_ready(19, low);
        issue(20, 3'b101, 2'b01, 2'b01, 1'b0, 2'b00, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0, 1, 2, 1);
        wait_ready(20, low);
        check(20, "div0 op_ready low cycles", low, 2);
        issue(21, 3'b100, 2'b01, 2'b01, 1'b0, 2'b00, 32'd0, 32'd12345, 32'd0, 32'd0, 0, 0, 33, 1);
        wait_ready(21, low);
        issue(22, 3'b101, 2'b01, 2'b01, 1'b0, 2'b00, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0, 1, 2, 1);
        wait_ready(22, low);

        // Flush ten cycles into a MUL: no result, outputs keep the last DIV-by-zero values
        issue(23, 3'b100, 2'b01, 2'b01, 1'b0, 2'b00, 32'd3, 32'd4, 0, 0, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check(23, "op_ready after flush", op_ready, 1);
        check(23, "z_out held", z_out, 32'hFFFFFFFF);
        check(23, "hi_out held", hi_out, 32'd9);
        check(23, "div0 held", div0, 1);

        // Flush beats op_valid in IDLE
        fntype = 3'b100; op_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0; flush = 1'b0;
        check(24, "flush wins over accept", op_ready, 1);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            prod = 64'(ra) * 64'(rb);
            issue(30 + i, 3'b100, 2'b01, 2'b01, 1'b0, 2'b00, ra, rb, prod[31:0], prod[63:32], 0, 0, 33, 1);
            wait_ready(30 + i, low);
            rb = $urandom_range(1, 32'hFFFF);
            issue(40 + i, 3'b101, 2'b01, 2'b01, 1'b0, 2'b00, ra, rb, ra / rb, ra % rb, 0, 0, 33, 1);
            wait_ready(40 + i, low);
        end

        // Reset mid-DIV clears everything asynchronously
        issue(50, 3'b101, 2'b01, 2'b01, 1'b0, 2'b00, 32'd1000, 32'd3, 0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check(50, "reset z_out", z_out, 0);
        check(50, "reset hi_out", hi_out, 0);
        check(50, "reset op_ready", op_ready, 1);
        check(50, "reset div0", div0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        issue(51, 3'b000, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h104, 0, 0, 0, 1, 1);
        repeat (3) @(negedge clk);
        check(52, "scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
